// File: rtl/arp_wavetable_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arp_wavetable_sequencer                                      |
// | Description : Arpeggiator plus wavetable address generator. A base period |
// |               (BASE_OFFSET + base_sel) is scaled by a per-step ratio in  |
// |               quarters. The result paces a phase-continuous BRAM read    |
// |               address. The step index walks the pattern in UP / DOWN /   |
// |               UPDOWN / HOLD order once every STEP_TICKS clocks.          |
// | Option      : define ARP_RANDOM_EN to turn mode 3 into RANDOM (LFSR).    |
// | Ports       : CLK100MHZ   in  system clock                               |
// |               CPU_RESETN  in  async reset, active low                    |
// |               arp_en      in  1 = arpeggiate, 0 = hold step 0            |
// |               mode        in  0 UP, 1 DOWN, 2 UPDOWN, 3 HOLD/RANDOM      |
// |               base_sel    in  base period offset                         |
// |               addr        out BRAM read address                          |
// |               sample_stb  out 1-cycle pulse on each addr advance         |
// |               step        out current step index                         |
// |               step_wrap   out 1-cycle pulse when the pattern restarts    |
// | Revision    : 1.0  initial release                                       |
// +----------------------------------------------------------------------------+
module arp_wavetable_sequencer #(
  parameter int          ADDR_W      = 8,
  parameter int          NUM_STEPS   = 4,
  parameter int          STEP_TICKS  = 50_000_000,
  parameter int          BASE_OFFSET = 746,
  parameter logic [63:0] RATIO_Q2    = 64'h4658,
  localparam int         STEP_W      = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              arp_en,
  input  logic [1:0]        mode,
  input  logic [7:0]        base_sel,
  output logic [ADDR_W-1:0] addr,
  output logic              sample_stb,
  output logic [STEP_W-1:0] step,
  output logic              step_wrap
);

  localparam int TIMER_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int BASE_W  = 16;
  localparam int LIM_W   = 18;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_TICKS - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W-1:0]  STEP_ONE   = STEP_W'(1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
  localparam logic [LIM_W-1:0]   CNT_ONE    = LIM_W'(1);

  // Mode 3 is HOLD in the default build and RANDOM when ARP_RANDOM_EN is set.
  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_UPDOWN = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

  mode_t              cur_mode;
  mode_t              prev_mode;  // mode seen at the previous step boundary
  logic [BASE_W-1:0]  base_q;
  logic [LIM_W-1:0]   cnt;
  logic [LIM_W-1:0]   limit;
  logic [5:0]         ratio_idx;
  logic [3:0]         ratio;
  logic [TIMER_W-1:0] timer;
  logic               dir;        // 0 = ascending, 1 = descending
  logic               dir_eff;
  logic               dir_nxt;
  logic [STEP_W-1:0]  step_nxt;
  logic               wrap_nxt;

  assign cur_mode = mode_t'(mode);

`ifdef ARP_RANDOM_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; free-running every clock.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
`endif

  // Divider limit P = (base_q * ratio) >> 2 at full width.
  always_comb begin
    ratio_idx = 6'({step, 2'b00});
    ratio     = RATIO_Q2[ratio_idx +: 4];
    limit     = LIM_W'(({4'b0000, base_q} * {16'h0000, ratio}) >> 2);
  end

  // Sample divider: never reset by step changes, so the waveform phase stays continuous.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      base_q     <= BASE_W'(BASE_OFFSET);
      cnt        <= '0;
      addr       <= '0;
      sample_stb <= 1'b0;
    end else begin
      base_q <= BASE_W'(BASE_OFFSET) + BASE_W'(base_sel);
      if (cnt >= limit) begin
        cnt        <= '0;
        addr       <= addr + ADDR_ONE;
        sample_stb <= 1'b1;
      end else begin
        cnt        <= cnt + CNT_ONE;
        sample_stb <= 1'b0;
      end
    end
  end

  // Next step/direction at a step boundary.
  always_comb begin
    step_nxt = step;
    dir_nxt  = dir;
    wrap_nxt = 1'b0;
    dir_eff  = dir;
    // Entering UPDOWN picks the direction that keeps the step inside the pattern.
    if (cur_mode == MODE_UPDOWN && prev_mode != MODE_UPDOWN) begin
      dir_eff = (step == STEP_LAST);
    end
    case (cur_mode)
      MODE_UP: begin
        if (step == STEP_LAST) begin
          step_nxt = '0;
          wrap_nxt = 1'b1;
        end else begin
          step_nxt = step + STEP_ONE;
        end
      end
      MODE_DOWN: begin
        if (step == '0) begin
          step_nxt = STEP_LAST;
          wrap_nxt = 1'b1;
        end else begin
          step_nxt = step - STEP_ONE;
        end
      end
      MODE_UPDOWN: begin
        dir_nxt = dir_eff;
        if (NUM_STEPS == 1) begin
          step_nxt = '0;
        end else if (!dir_eff) begin
          if (step == STEP_LAST) begin
            step_nxt = step - STEP_ONE;
            dir_nxt  = 1'b1;
          end else begin
            step_nxt = step + STEP_ONE;
          end
        end else begin
          if (step == '0) begin
            step_nxt = step + STEP_ONE;
            dir_nxt  = 1'b0;
          end else begin
            step_nxt = step - STEP_ONE;
          end
        end
        wrap_nxt = (step_nxt == '0);
      end
`ifdef ARP_RANDOM_EN
      MODE_HOLD: begin
        step_nxt = STEP_W'({1'b0, lfsr[3:0]} % 5'(NUM_STEPS));
        wrap_nxt = (step_nxt == '0);
      end
`else
      MODE_HOLD: begin
        step_nxt = step;
      end
`endif
      default: begin
        step_nxt = step;
      end
    endcase
  end

  // Step timer and pattern state.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      timer     <= '0;
      step      <= '0;
      dir       <= 1'b0;
      prev_mode <= MODE_UP;
      step_wrap <= 1'b0;
    end else if (!arp_en) begin
      timer     <= '0;
      step      <= '0;
      dir       <= 1'b0;
      step_wrap <= 1'b0;
    end else if (timer == TIMER_LAST) begin
      timer     <= '0;
      step      <= step_nxt;
      dir       <= dir_nxt;
      prev_mode <= cur_mode;
      step_wrap <= wrap_nxt;
    end else begin
      timer     <= timer + TIMER_W'(1);
      step_wrap <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arp_wavetable_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_arp_wavetable_sequencer                                   |
// | Description : Directed self-checking bench for arp_wavetable_sequencer    |
// |               with STEP_TICKS=10 and a 4-bit address.                    |
// | Revision    : 1.0  initial release                                       |
// +----------------------------------------------------------------------------+
module tb_arp_wavetable_sequencer;

  localparam int ADDR_W     = 4;
  localparam int NUM_STEPS  = 4;
  localparam int STEP_TICKS = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              arp_en;
  logic [1:0]        mode;
  logic [7:0]        base_sel;
  logic [ADDR_W-1:0] addr;
  logic              sample_stb;
  logic [1:0]        step;
  logic              step_wrap;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arp_wavetable_sequencer #(
    .ADDR_W      (ADDR_W),
    .NUM_STEPS   (NUM_STEPS),
    .STEP_TICKS  (STEP_TICKS),
    .BASE_OFFSET (746),
    .RATIO_Q2    (64'h4658)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .arp_en     (arp_en),
    .mode       (mode),
    .base_sel   (base_sel),
    .addr       (addr),
    .sample_stb (sample_stb),
    .step       (step),
    .step_wrap  (step_wrap)
  );

  // Counts negedges until sample_stb is seen; -1 if the bound expires.
  task automatic wait_stb(input int bound, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!sample_stb && cycles < bound);
    if (!sample_stb) cycles = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; arp_en = 1'b0; mode = 2'd0; base_sel = 8'd0;
    repeat (3) @(negedge clk);
    n_cmp++; if (addr !== 4'd0) begin n_bad++; $display("FAIL reset_addr: got %0d expected 0", addr); end
    n_cmp++; if (sample_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b expected 0", sample_stb); end
    n_cmp++; if (step !== 2'd0) begin n_bad++; $display("FAIL reset_step: got %0d expected 0", step); end
    n_cmp++; if (step_wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b expected 0", step_wrap); end
    rst_n = 1'b1;
  endtask

  // Step 0 (ratio 8), base 746 -> P = 1492, period 1493.
  task automatic test_divider;
    int c;
    wait_stb(1600, c);
    n_cmp++; if (c !== 1493) begin n_bad++; $display("FAIL div_first: got %0d expected 1493", c); end
    n_cmp++; if (addr !== 4'd1) begin n_bad++; $display("FAIL div_first_addr: got %0d expected 1", addr); end
    for (int i = 0; i < 2; i++) begin
      wait_stb(1600, c);
      n_cmp++; if (c !== 1493) begin n_bad++; $display("FAIL div_period%0d: got %0d expected 1493", i, c); end
    end
    for (int i = 0; i < 20 && addr !== 4'd15; i++) wait_stb(1600, c);
    n_cmp++; if (addr !== 4'd15) begin n_bad++; $display("FAIL div_reach_top: got %0d expected 15", addr); end
    wait_stb(1600, c);
    n_cmp++; if (addr !== 4'd0) begin n_bad++; $display("FAIL div_wrap_addr: got %0d expected 0", addr); end
    n_cmp++; if (c !== 1493) begin n_bad++; $display("FAIL div_wrap_period: got %0d expected 1493", c); end
  endtask

  task automatic test_up;
    logic [1:0] exp_s;
    logic       exp_w;
    mode = 2'd0; arp_en = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      exp_s = 2'((n / 10) % 4);
      exp_w = (n % 10 == 0) && ((n / 10) % 4 == 0);
      n_cmp++; if (step !== exp_s) begin n_bad++; $display("FAIL up_step n=%0d: got %0d expected %0d", n, step, exp_s); end
      n_cmp++; if (step_wrap !== exp_w) begin n_bad++; $display("FAIL up_wrap n=%0d: got %b expected %b", n, step_wrap, exp_w); end
    end
    arp_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (step !== 2'd0) begin n_bad++; $display("FAIL up_disable_step: got %0d expected 0", step); end
  endtask

  task automatic test_updown;
    logic [1:0] seq [6];
    logic [1:0] exp_s;
    logic       exp_w;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd2; seq[5] = 2'd1;
    mode = 2'd2; arp_en = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      exp_s = seq[(n / 10) % 6];
      exp_w = (n % 10 == 0) && (exp_s == 2'd0);
      n_cmp++; if (step !== exp_s) begin n_bad++; $display("FAIL ud_step n=%0d: got %0d expected %0d", n, step, exp_s); end
      n_cmp++; if (step_wrap !== exp_w) begin n_bad++; $display("FAIL ud_wrap n=%0d: got %b expected %b", n, step_wrap, exp_w); end
    end
    arp_en = 1'b0;
    @(negedge clk);
  endtask

  // UPDOWN up to step 3, then DOWN: 2,1,0 and wrap onto 3.
  task automatic test_mode_switch;
    logic [1:0] exp_s;
    logic       exp_w;
    mode = 2'd2; arp_en = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++; if (step !== 2'd3) begin n_bad++; $display("FAIL sw_at3: got %0d expected 3", step); end
    mode = 2'd1;
    for (int n = 31; n <= 70; n++) begin
      @(negedge clk);
      exp_s = (n < 40) ? 2'd3 : (n < 50) ? 2'd2 : (n < 60) ? 2'd1 : (n < 70) ? 2'd0 : 2'd3;
      exp_w = (n == 70);
      n_cmp++; if (step !== exp_s) begin n_bad++; $display("FAIL sw_step n=%0d: got %0d expected %0d", n, step, exp_s); end
      n_cmp++; if (step_wrap !== exp_w) begin n_bad++; $display("FAIL sw_wrap n=%0d: got %b expected %b", n, step_wrap, exp_w); end
    end
    arp_en = 1'b0;
    @(negedge clk);
  endtask

  // Hold each step in turn and measure P+1: 1493, 933, 1120, 747.
  task automatic test_ratio;
    int per [4];
    int c;
    per[0] = 1493; per[1] = 933; per[2] = 1120; per[3] = 747;
    for (int k = 0; k < 4; k++) begin
      arp_en = 1'b0;
      @(negedge clk);
      mode = 2'd0; arp_en = 1'b1;
      repeat (10 * k) @(negedge clk);
      mode = 2'd3;
      n_cmp++; if (step !== 2'(k)) begin n_bad++; $display("FAIL ratio_step%0d: got %0d expected %0d", k, step, k); end
      wait_stb(3000, c);
      wait_stb(3000, c);
      n_cmp++; if (c !== per[k]) begin n_bad++; $display("FAIL ratio_period%0d: got %0d expected %0d", k, c, per[k]); end
      n_cmp++; if (step !== 2'(k)) begin n_bad++; $display("FAIL hold_step%0d: got %0d expected %0d", k, step, k); end
    end
    arp_en = 1'b0; mode = 2'd0;
    @(negedge clk);
  endtask

  task automatic test_base_change;
    int c;
    logic [ADDR_W-1:0] a0;
    base_sel = 8'd255;
    wait_stb(2100, c);
    wait_stb(2100, c);
    n_cmp++; if (c !== 2003) begin n_bad++; $display("FAIL base_max_period: got %0d expected 2003", c); end
    // Lower the base while cnt is below the new limit.
    a0 = addr + 4'd1;
    repeat (1000) @(negedge clk);
    base_sel = 8'd0;
    wait_stb(2100, c);
    n_cmp++; if (1000 + c !== 1493) begin n_bad++; $display("FAIL base_down_period: got %0d expected 1493", 1000 + c); end
    n_cmp++; if (addr !== a0) begin n_bad++; $display("FAIL base_down_addr: got %0d expected %0d", addr, a0); end
    base_sel = 8'd255;
    wait_stb(2100, c);
    n_cmp++; if (c !== 2003) begin n_bad++; $display("FAIL base_up_period: got %0d expected 2003", c); end
    // Lower the base while cnt is already past the new limit: advance one cycle after base_q updates.
    a0 = addr + 4'd1;
    repeat (1600) @(negedge clk);
    base_sel = 8'd0;
    wait_stb(2100, c);
    n_cmp++; if (1600 + c !== 1602) begin n_bad++; $display("FAIL base_late_period: got %0d expected 1602", 1600 + c); end
    n_cmp++; if (addr !== a0) begin n_bad++; $display("FAIL base_late_addr: got %0d expected %0d", addr, a0); end
  endtask

  task automatic test_disable;
    int c;
    logic [ADDR_W-1:0] a0;
    wait_stb(1600, c);
    a0 = addr + 4'd1;
    mode = 2'd0; arp_en = 1'b1;
    repeat (25) @(negedge clk);
    n_cmp++; if (step !== 2'd2) begin n_bad++; $display("FAIL dis_pre_step: got %0d expected 2", step); end
    arp_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (step !== 2'd0) begin n_bad++; $display("FAIL dis_step: got %0d expected 0", step); end
    arp_en = 1'b1;
    repeat (9) @(negedge clk);
    n_cmp++; if (step !== 2'd0) begin n_bad++; $display("FAIL reen_hold: got %0d expected 0", step); end
    @(negedge clk);
    n_cmp++; if (step !== 2'd1) begin n_bad++; $display("FAIL reen_step: got %0d expected 1", step); end
    arp_en = 1'b0;
    // Divider count continued through the whole episode.
    wait_stb(1600, c);
    n_cmp++; if (36 + c !== 1493) begin n_bad++; $display("FAIL dis_period: got %0d expected 1493", 36 + c); end
    n_cmp++; if (addr !== a0) begin n_bad++; $display("FAIL dis_addr: got %0d expected %0d", addr, a0); end
  endtask

  task automatic test_reset_midrun;
    int c;
    mode = 2'd0; arp_en = 1'b1;
    repeat (13) @(negedge clk);
    n_cmp++; if (step !== 2'd1) begin n_bad++; $display("FAIL mid_pre_step: got %0d expected 1", step); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (addr !== 4'd0) begin n_bad++; $display("FAIL mid_addr: got %0d expected 0", addr); end
    n_cmp++; if (sample_stb !== 1'b0) begin n_bad++; $display("FAIL mid_stb: got %b expected 0", sample_stb); end
    n_cmp++; if (step !== 2'd0) begin n_bad++; $display("FAIL mid_step: got %0d expected 0", step); end
    n_cmp++; if (step_wrap !== 1'b0) begin n_bad++; $display("FAIL mid_wrap: got %b expected 0", step_wrap); end
    @(negedge clk);
    arp_en = 1'b0;
    rst_n = 1'b1;
    wait_stb(1600, c);
    n_cmp++; if (c !== 1493) begin n_bad++; $display("FAIL mid_resume_period: got %0d expected 1493", c); end
    n_cmp++; if (addr !== 4'd1) begin n_bad++; $display("FAIL mid_resume_addr: got %0d expected 1", addr); end
  endtask

  initial begin
    test_reset;
    test_divider;
    test_up;
    test_updown;
    test_mode_switch;
    test_ratio;
    test_base_change;
    test_disable;
    test_reset_midrun;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
